// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared state codes and handshake constants for the sequential divider
package div_seq_pkg;
  localparam int DIV_WIDTH = 32;
  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
endpackage

// File: rtl/div_seq_if.sv
// div_seq_if: EX-stage to divider request/result bundle
interface div_seq_if import div_seq_pkg::*; #(parameter int WIDTH = DIV_WIDTH);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_seq_step.sv
// div_seq_step: one restoring trial-subtract/shift iteration of the divider
module div_seq_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] r_o,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH:0] trial;
  assign trial = {r_i, q_i[WIDTH-1]} - {1'b0, d_i};
  assign r_o   = trial[WIDTH] ? {r_i[WIDTH-2:0], q_i[WIDTH-1]} : trial[WIDTH-1:0];
  assign q_o   = {q_i[WIDTH-2:0], ~trial[WIDTH]};
endmodule

// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider (DIV/DIVU) returning {HI=rem, LO=quot}
module div_seq import div_seq_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic        clk,
  input logic        rst,
  div_seq_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);
  div_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   r_q, r_d, q_q, q_d, dv_q, dv_d;
  logic               rneg_q, rneg_d, qneg_q, qneg_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;
  logic [WIDTH-1:0]   r_nx, q_nx, op1_abs, op2_abs;
  logic               go, stop, last;
  assign go      = bus.start_i == DIV_START && !bus.annul_i;
  assign stop    = bus.annul_i || bus.start_i == DIV_STOP;
  assign last    = cnt_q == CW'(WIDTH - 1);
  assign op1_abs = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
  assign op2_abs = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;
  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  div_seq_step #(.WIDTH(WIDTH)) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (dv_q),
    .r_o (r_nx),
    .q_o (q_nx)
  );
  // next state: accept/latch in FREE, iterate in ON, sign-fix on the final iteration
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    q_d      = q_q;
    dv_d     = dv_q;
    rneg_d   = rneg_q;
    qneg_d   = qneg_q;
    result_d = result_q;
    ready_d  = ready_q;
    case (state_q)
      DIV_FREE: begin
        result_d = '0;
        ready_d  = DIV_RESULT_NOT_READY;
        if (go) begin
          state_d = bus.opdata2_i == '0 ? DIV_BYZERO : DIV_ON;
          cnt_d   = '0;
          r_d     = '0;
          q_d     = op1_abs;
          dv_d    = op2_abs;
          rneg_d  = bus.signed_div_i && bus.opdata1_i[WIDTH-1];
          qneg_d  = bus.signed_div_i && (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
        end
      end
      DIV_BYZERO: begin
        state_d  = stop ? DIV_FREE : DIV_END;
        ready_d  = stop ? DIV_RESULT_NOT_READY : DIV_RESULT_READY;
        result_d = '0;
      end
      DIV_ON: begin
        if (stop) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end else begin
          r_d   = r_nx;
          q_d   = q_nx;
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            state_d  = DIV_END;
            ready_d  = DIV_RESULT_READY;
            result_d = {rneg_q ? -r_nx : r_nx, qneg_q ? -q_nx : q_nx};
          end
        end
      end
      DIV_END: begin
        if (stop) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end
      end
      default: state_d = DIV_FREE;
    endcase
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DIV_FREE;
      cnt_q    <= '0;
      r_q      <= '0;
      q_q      <= '0;
      dv_q     <= '0;
      rneg_q   <= 1'b0;
      qneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= DIV_RESULT_NOT_READY;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      q_q      <= q_d;
      dv_q     <= dv_d;
      rneg_q   <= rneg_d;
      qneg_q   <= qneg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: randomized self-checking bench for div_seq against an arithmetic reference
module tb_div_seq;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  div_seq_if #(.WIDTH(W)) bus ();
  div_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (!sg) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {r, q};
  endfunction
  task automatic run_op(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int n;
    exp = ref_div(sg, a, b);
    n = (b == 32'd0) ? 2 : W + 1;
    bus.signed_div_i = sg;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    for (int e = 1; e < n; e++) begin
      @(posedge clk);
      #1;
      if (e == 3) begin
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = ~sg;
      end
    end
    chk({tag, "_early"}, {63'd0, bus.ready_o}, 64'd0);
    @(posedge clk);
    #1;
    chk({tag, "_ready"}, {63'd0, bus.ready_o}, 64'd1);
    chk({tag, "_result"}, bus.result_o, exp);
    @(posedge clk);
    #1;
    chk({tag, "_hold"}, bus.result_o, exp);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_drop"}, {bus.ready_o, bus.result_o}, 65'd0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic seen;
    logic [31:0] a, b;
    int r;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", {bus.ready_o, bus.result_o}, 65'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_op("u100_7", 1'b0, 32'd100, 32'd7);
    run_op("s-7_2", 1'b1, -32'sd7, 32'd2);
    run_op("s7_-2", 1'b1, 32'd7, -32'sd2);
    run_op("u_div0", 1'b0, 32'd55, 32'd0);
    run_op("s_div0", 1'b1, 32'hFFFF_FF00, 32'd0);
    run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("u_max", 1'b0, 32'hFFFF_FFFF, 32'd1);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd50;
    bus.opdata2_i    = 32'd0;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b1;
    @(posedge clk);
    #1;
    bus.annul_i = 1'b0;
    @(posedge clk);
    #1;
    chk("startannul_e1", {63'd0, bus.ready_o}, 64'd0);
    @(posedge clk);
    #1;
    chk("startannul_e2", {63'd0, bus.ready_o}, 64'd1);
    bus.start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.opdata1_i = 32'd50;
    bus.opdata2_i = 32'd5;
    bus.start_i   = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    bus.annul_i = 1'b1;
    @(posedge clk);
    #1;
    chk("annul_free", {bus.ready_o, bus.result_o}, 65'd0);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      seen |= bus.ready_o;
    end
    chk("annul_noready", {63'd0, seen}, 64'd0);
    run_op("u9_3", 1'b0, 32'd9, 32'd3);
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    repeat (W + 1) @(posedge clk);
    #1;
    chk("pre_rst_ready", {63'd0, bus.ready_o}, 64'd1);
    #2;
    rst = 1'b0;
    bus.start_i = 1'b0;
    #1;
    chk("rst_end", {bus.ready_o, bus.result_o}, 65'd0);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b1;
    repeat (15) @(posedge clk);
    #3;
    rst = 1'b0;
    bus.start_i = 1'b0;
    #1;
    chk("rst_on", {bus.ready_o, bus.result_o}, 65'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_op("post_rst", 1'b1, -32'sd100, 32'd7);
    for (int i = 0; i < 20; i++) begin
      r = $urandom_range(0, 9);
      a = $urandom;
      b = (r < 1) ? 32'd0 : (r < 5) ? $urandom_range(1, 20) : (r < 6) ? 32'hFFFF_FFFF : $urandom;
      run_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a, b);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
